// File: rtl/stage_memory.sv
// Memory pipeline stage: issues single-outstanding data-memory accesses, resolves
// branches/jumps into a registered redirect and produces registered writeback results.
module stage_memory (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_data0,
  input  logic [31:0] mem_data1,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_extend,
  input  logic [1:0]  mem_width,
  input  logic        mem_jmp,
  input  logic        mem_br,
  input  logic        mem_br_inv,
  input  logic [4:0]  wb_reg,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        mem_misaligned,
  output logic [31:0] fault_pc,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg_r
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q;
  logic        dmem_req_q, dmem_we_q, br_taken_q, mem_misaligned_q, wb_valid_q;
  logic [31:0] dmem_addr_q, dmem_wdata_q, br_target_q, fault_pc_q, wb_data_q;
  logic [3:0]  dmem_wstrb_q;
  logic [4:0]  wb_reg_q, pend_reg_q;
  logic [1:0]  lo_q, width_q;
  logic        ext_q;

  logic        memop, mis;
  logic [3:0]  strb;
  logic [31:0] wdata, shifted, load_data;

  always_comb begin
    memop = mem_valid & (mem_read | mem_write);
    unique case (mem_width)
      2'd0:    mis = 1'b0;
      2'd1:    mis = mem_data0[0];
      2'd2:    mis = |mem_data0[1:0];
      default: mis = 1'b1;
    endcase
    unique case (mem_width)
      2'd0:    begin strb = 4'b0001 << mem_data0[1:0]; wdata = {4{mem_data1[7:0]}};  end
      2'd1:    begin strb = 4'b0011 << mem_data0[1:0]; wdata = {2{mem_data1[15:0]}}; end
      default: begin strb = 4'b1111;                   wdata = mem_data1;            end
    endcase
    // Lane select uses the address bits captured when the request was issued.
    shifted = dmem_rdata >> {lo_q, 3'b000};
    unique case (width_q)
      2'd0:    load_data = {{24{ext_q & shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = {{16{ext_q & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
    mem_stall = (state_q == StIdle) ? (memop & ~mis) : ~dmem_ack;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      dmem_req_q       <= 1'b0;
      dmem_we_q        <= 1'b0;
      dmem_addr_q      <= '0;
      dmem_wdata_q     <= '0;
      dmem_wstrb_q     <= '0;
      br_taken_q       <= 1'b0;
      br_target_q      <= '0;
      mem_misaligned_q <= 1'b0;
      fault_pc_q       <= '0;
      wb_valid_q       <= 1'b0;
      wb_data_q        <= '0;
      wb_reg_q         <= '0;
      pend_reg_q       <= '0;
      lo_q             <= '0;
      width_q          <= '0;
      ext_q            <= 1'b0;
    end else begin
      br_taken_q       <= 1'b0;
      mem_misaligned_q <= 1'b0;
      wb_valid_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (memop && mis) begin
            mem_misaligned_q <= 1'b1;
            fault_pc_q       <= mem_pc;
          end else if (memop) begin
            dmem_req_q   <= 1'b1;
            dmem_we_q    <= mem_write;
            dmem_addr_q  <= {mem_data0[31:2], 2'b00};
            dmem_wstrb_q <= mem_write ? strb : 4'b0000;
            dmem_wdata_q <= wdata;
            lo_q         <= mem_data0[1:0];
            width_q      <= mem_width;
            ext_q        <= mem_extend;
            pend_reg_q   <= wb_reg;
            state_q      <= StBusy;
          end else if (mem_valid) begin
            wb_reg_q <= wb_reg;
            if (mem_jmp) begin
              br_taken_q  <= 1'b1;
              br_target_q <= mem_data1;
              wb_valid_q  <= 1'b1;
              wb_data_q   <= mem_data0;
            end else if (mem_br) begin
              br_taken_q  <= mem_data0[0] ^ mem_br_inv;
              br_target_q <= mem_data1;
            end else begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= mem_data0;
            end
          end
        end
        StBusy: begin
          if (dmem_ack) begin
            dmem_req_q <= 1'b0;
            state_q    <= StIdle;
            wb_reg_q   <= pend_reg_q;
            wb_valid_q <= ~dmem_we_q;
            if (!dmem_we_q) wb_data_q <= load_data;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dmem_req       = dmem_req_q;
  assign dmem_we        = dmem_we_q;
  assign dmem_addr      = dmem_addr_q;
  assign dmem_wdata     = dmem_wdata_q;
  assign dmem_wstrb     = dmem_wstrb_q;
  assign br_taken       = br_taken_q;
  assign br_target      = br_target_q;
  assign mem_misaligned = mem_misaligned_q;
  assign fault_pc       = fault_pc_q;
  assign wb_valid       = wb_valid_q;
  assign wb_data        = wb_data_q;
  assign wb_reg_r       = wb_reg_q;

endmodule

// File: tb/tb_stage_memory.sv
// Self-checking bench for stage_memory: directed cases plus randomized ops against
// an arithmetic reference model of lanes, strobes, extension and timing.
module tb_stage_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_pc = '0, mem_data0 = '0, mem_data1 = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0, mem_extend = 1'b0;
  logic [1:0]  mem_width = '0;
  logic        mem_jmp = 1'b0, mem_br = 1'b0, mem_br_inv = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic        mem_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        br_taken, mem_misaligned, wb_valid;
  logic [31:0] br_target, fault_pc, wb_data;
  logic [4:0]  wb_reg_r;

  int errors = 0;
  int checks = 0;

  stage_memory dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_data0(mem_data0), .mem_data1(mem_data1), .mem_read(mem_read),
    .mem_write(mem_write), .mem_extend(mem_extend), .mem_width(mem_width),
    .mem_jmp(mem_jmp), .mem_br(mem_br), .mem_br_inv(mem_br_inv), .wb_reg(wb_reg),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .br_taken(br_taken), .br_target(br_target),
    .mem_misaligned(mem_misaligned), .fault_pc(fault_pc), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_reg_r(wb_reg_r)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arithmetic on sizes and lanes.
  function automatic int unsigned ref_bytes(input logic [1:0] w);
    return 1 << w;
  endfunction

  function automatic bit ref_mis(input logic [1:0] w, input logic [31:0] a);
    if (w == 2'd3) return 1'b1;
    return (a % ref_bytes(w)) != 0;
  endfunction

  function automatic logic [3:0] ref_strb(input logic [1:0] w, input logic [31:0] a);
    int unsigned m;
    m = (1 << ref_bytes(w)) - 1;
    return 4'((m << (a % 4)) & 15);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] w, input logic [31:0] d);
    longint unsigned v;
    if (w == 2'd0) v = (longint'(d) % 256) * 64'h0101_0101;
    else if (w == 2'd1) v = (longint'(d) % 65536) * 64'h0001_0001;
    else v = longint'(d);
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] w, input bit ext);
    longint v;
    int unsigned bits;
    v = longint'(rd) / (64'd1 << (8 * (a % 4)));
    bits = 8 * ref_bytes(w);
    if (bits < 32) begin
      v = v % (64'd1 << bits);
      if (ext && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    end
    return v[31:0];
  endfunction

  task automatic drive_common(input logic [31:0] pc, input logic [31:0] d0,
                              input logic [31:0] d1, input logic [4:0] rg);
    mem_valid = 1'b1;
    mem_pc    = pc;
    mem_data0 = d0;
    mem_data1 = d1;
    wb_reg    = rg;
  endtask

  // Non-memory op; kind 0 = ALU, 1 = jump, 2 = branch.
  task automatic do_exe(input int kind, input bit inv, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [4:0] rg);
    bit exp_taken, exp_wbv;
    drive_common($urandom, d0, d1, rg);
    mem_read = 1'b0; mem_write = 1'b0;
    mem_jmp = (kind == 1); mem_br = (kind == 2); mem_br_inv = inv;
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin
      errors++; $display("FAIL exe_stall: got %b want 0", mem_stall);
    end
    cyc();
    mem_valid = 1'b0; mem_jmp = 1'b0; mem_br = 1'b0;
    exp_taken = (kind == 1) || (kind == 2 && ((d0 % 2 == 1) != inv));
    exp_wbv   = (kind != 2);
    checks++;
    if ({br_taken, wb_valid, dmem_req, mem_misaligned} !== {exp_taken, exp_wbv, 2'b00}) begin
      errors++;
      $display("FAIL exe_flags kind=%0d: taken/wbv/req/mis got %b%b%b%b want %b%b00", kind,
               br_taken, wb_valid, dmem_req, mem_misaligned, exp_taken, exp_wbv);
    end
    if (kind != 0) begin
      checks++;
      if (br_target !== d1) begin
        errors++; $display("FAIL exe_target: got %h want %h", br_target, d1);
      end
    end
    if (exp_wbv) begin
      checks++;
      if ({wb_data, wb_reg_r} !== {d0, rg}) begin
        errors++;
        $display("FAIL exe_wb: got %h/%0d want %h/%0d", wb_data, wb_reg_r, d0, rg);
      end
    end
  endtask

  // Memory op with ack arriving k cycles after the arrival cycle.
  task automatic do_mem(input bit wr, input logic [1:0] w, input bit ext,
                        input logic [31:0] a, input logic [31:0] d1, input int k,
                        input logic [31:0] rdata, input logic [4:0] rg);
    logic [31:0] pc;
    int stalls;
    pc = $urandom;
    drive_common(pc, a, d1, rg);
    mem_read = ~wr; mem_write = wr; mem_width = w; mem_extend = ext;
    mem_jmp = 1'b0; mem_br = 1'b0;
    #1;
    if (ref_mis(w, a)) begin
      checks++;
      if (mem_stall !== 1'b0) begin
        errors++; $display("FAIL mis_stall: got %b want 0", mem_stall);
      end
      cyc();
      mem_valid = 1'b0;
      checks++;
      if ({mem_misaligned, fault_pc, wb_valid, dmem_req} !== {1'b1, pc, 2'b00}) begin
        errors++;
        $display("FAIL misaligned: mis/pc/wbv/req got %b/%h/%b/%b want 1/%h/0/0",
                 mem_misaligned, fault_pc, wb_valid, dmem_req, pc);
      end
      return;
    end
    stalls = mem_stall ? 1 : 0;
    cyc();
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wstrb} !==
        {1'b1, wr, a & 32'hFFFF_FFFC, wr ? ref_strb(w, a) : 4'b0000}) begin
      errors++;
      $display("FAIL req: req/we/addr/strb got %b/%b/%h/%b want 1/%b/%h/%b", dmem_req,
               dmem_we, dmem_addr, dmem_wstrb, wr, a & 32'hFFFF_FFFC,
               wr ? ref_strb(w, a) : 4'b0000);
    end
    if (wr) begin
      checks++;
      if (dmem_wdata !== ref_wdata(w, d1)) begin
        errors++; $display("FAIL wdata: got %h want %h", dmem_wdata, ref_wdata(w, d1));
      end
    end
    for (int i = 1; i < k; i++) begin
      if (mem_stall) stalls++;
      cyc();
    end
    dmem_ack = 1'b1;
    dmem_rdata = rdata;
    #1;
    if (mem_stall) stalls++;
    checks++;
    if (stalls != k) begin
      errors++; $display("FAIL stall_count: got %0d want %0d", stalls, k);
    end
    cyc();
    dmem_ack = 1'b0; mem_valid = 1'b0; dmem_rdata = $urandom;
    checks++;
    if ({wb_valid, dmem_req} !== {~wr, 1'b0}) begin
      errors++;
      $display("FAIL mem_done: wbv/req got %b/%b want %b/0", wb_valid, dmem_req, ~wr);
    end
    if (!wr) begin
      checks++;
      if ({wb_data, wb_reg_r} !== {ref_load(rdata, a, w, ext), rg}) begin
        errors++;
        $display("FAIL load_data: got %h/%0d want %h/%0d", wb_data, wb_reg_r,
                 ref_load(rdata, a, w, ext), rg);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    checks++;
    if ({dmem_req, dmem_we, br_taken, mem_misaligned, wb_valid, mem_stall} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b%b%b%b%b%b want 000000", dmem_req, dmem_we,
                         br_taken, mem_misaligned, wb_valid, mem_stall);
    end
    checks++;
    if ({dmem_addr, dmem_wdata, br_target, fault_pc, wb_data, dmem_wstrb, wb_reg_r} !== '0) begin
      errors++; $display("FAIL reset_values: addr %h wdata %h tgt %h fpc %h wbd %h strb %b reg %0d",
                         dmem_addr, dmem_wdata, br_target, fault_pc, wb_data, dmem_wstrb, wb_reg_r);
    end
  endtask

  task automatic test_directed();
    do_exe(0, 1'b0, 32'h1234, 32'h0, 5'd5);
    do_mem(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 4, 32'h80FF_FFFF, 5'd7);
    checks++;
    if (wb_data !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL lb_const: got %h want ffffff80", wb_data);
    end
    do_mem(1'b1, 2'd1, 1'b0, 32'h202, 32'hABCD, 2, 32'h0, 5'd3);
    do_mem(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 1, 32'h0, 5'd4);
    do_exe(2, 1'b1, 32'h0, 32'h40, 5'd0);
    do_exe(1, 1'b0, 32'h14, 32'h80, 5'd1);
  endtask

  task automatic test_idle();
    mem_valid = 1'b0;
    dmem_ack = 1'b1;
    cyc(); cyc();
    dmem_ack = 1'b0;
    checks++;
    if ({br_taken, mem_misaligned, wb_valid, dmem_req, mem_stall} !== 5'b0) begin
      errors++; $display("FAIL idle_pulses: got %b%b%b%b%b want 00000", br_taken,
                         mem_misaligned, wb_valid, dmem_req, mem_stall);
    end
  endtask

  task automatic test_reset_busy();
    do_exe(0, 1'b0, 32'hCAFE, 32'h0, 5'd9);
    drive_common(32'h500, 32'h300, 32'h0, 5'd2);
    mem_read = 1'b1; mem_write = 1'b0; mem_width = 2'd2;
    cyc();
    mem_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1111_2222;
    #1;
    checks++;
    if ({dmem_req, mem_stall} !== 2'b00) begin
      errors++; $display("FAIL rst_busy_req: req/stall got %b/%b want 0/0", dmem_req, mem_stall);
    end
    cyc();
    dmem_ack = 1'b0;
    checks++;
    if ({wb_valid, dmem_req} !== 2'b00) begin
      errors++; $display("FAIL rst_busy_ack: wbv/req got %b/%b want 0/0", wb_valid, dmem_req);
    end
    do_exe(0, 1'b0, 32'h77, 32'h0, 5'd11);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  w;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_exe($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom, $urandom,
               5'($urandom_range(0, 31)));
      end else begin
        w = 2'($urandom_range(0, 3));
        a = $urandom;
        if ($urandom_range(0, 3) != 0 && w != 2'd3) a = a - (a % ref_bytes(w));
        do_mem(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), a, $urandom,
               $urandom_range(1, 4), $urandom, 5'($urandom_range(0, 31)));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 6; n++) begin
      do_mem(n % 2 == 1, 2'd0, 1'b0, 32'h40 + n, 32'h5A + n, 1 + (n % 3), 32'h0403_0201,
             5'(n + 1));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_idle();
    test_back_to_back();
    test_reset_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stage_memory.md
# stage_memory

Pipeline stage directly downstream of `stage_execute`; consumes its registered ALU/branch results and control bits. Performs data-memory loads/stores over a single-outstanding request/ack port, resolves branches and jumps into a registered redirect, and produces registered writeback results. Back-pressures execute via `mem_stall` while a memory access is in flight.

## Interface
- No parameters.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_valid` in 1: instruction present; held stable with all inputs below while `mem_stall`=1.
- `mem_pc` in 32: instruction PC.
- `mem_data0` in 32: ALU result: address, compare result, link value or ALU value.
- `mem_data1` in 32: store data, or branch/jump target.
- `mem_read`, `mem_write` in 1: load / store.
- `mem_extend` in 1: 1 = sign-extend load, 0 = zero-extend.
- `mem_width` in 2: 0 byte, 1 half, 2 word, 3 illegal.
- `mem_jmp`, `mem_br`, `mem_br_inv` in 1: jump; conditional branch; invert condition.
- `wb_reg` in 5: destination register.
- `mem_stall` out 1: execute must hold.
- `dmem_req` out 1: request valid, held until ack.
- `dmem_we` out 1: store.
- `dmem_addr` out 32: word-aligned address.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_wstrb` out 4: byte enables.
- `dmem_ack` in 1: request complete this cycle.
- `dmem_rdata` in 32: load word, valid with ack.
- `br_taken` out 1: one-cycle redirect pulse.
- `br_target` out 32: redirect PC.
- `mem_misaligned` out 1: one-cycle fault pulse.
- `fault_pc` out 32: PC of faulting access.
- `wb_valid` out 1: writeback result valid for one cycle.
- `wb_data` out 32, `wb_reg_r` out 5: writeback value / destination.

## Operation
- FSM: IDLE, BUSY.
- `memop` = `mem_valid` & (`mem_read`|`mem_write`). `mis` = width 3, or half with addr[0]=1, or word with addr[1:0]≠0.
- IDLE, `memop` & ~`mis`: register `dmem_req`=1, `dmem_we`=`mem_write`, `dmem_addr`={data0[31:2],2'b00}, strobes/wdata; go BUSY. `mem_stall`=1 combinationally this cycle.
- IDLE, `memop` & `mis`: no request, no stall; next cycle `mem_misaligned`=1, `fault_pc`=`mem_pc`, `wb_valid`=0.
- BUSY: `mem_stall`=~`dmem_ack`. On ack: `dmem_req`←0, state←IDLE; load: `wb_valid`←1, `wb_data`←extracted data; store: `wb_valid`←0.
- Strobes: byte 4'b0001<<a[1:0]; half 4'b0011<<a[1:0]; word 4'b1111. Wdata: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- Load extract: `dmem_rdata`>>(8·a[1:0]), then extend low 8/16 bits per `mem_extend`. a = BUSY-latched address low bits.
- Non-memop valid: one-cycle pass-through. Jump: `br_taken`←1, `br_target`←data1, `wb_valid`←1, `wb_data`←data0. Branch: `br_taken`←data0[0]^`mem_br_inv`, `br_target`←data1, `wb_valid`←0. Other: `wb_valid`←1, `wb_data`←data0.
- `wb_reg_r` latched with every `wb_valid` update. `dmem_ack` in IDLE is ignored.

## Timing
- Reset: state IDLE; `dmem_req`, `dmem_we`, `br_taken`, `mem_misaligned`, `wb_valid` = 0; `dmem_addr`, `dmem_wdata`, `br_target`, `fault_pc`, `wb_data` = 0; `dmem_wstrb`, `wb_reg_r` = 0. Reset in BUSY drops the request next cycle; later ack ignored.
- ALU/jump/branch: result or redirect registered 1 cycle after arrival, no stall.
- Memory: arrival cycle N (stall); `dmem_req` high from N+1; ack at N+k (k≥1) drops stall that cycle; `wb_valid` at N+k+1. Minimum 2 stalled-or-busy cycles per access.
- Back-to-back memops: next op enters IDLE at N+k+1, request at N+k+2.
- `mem_valid`=0: all pulse outputs 0 next cycle.

## Test plan
- ADD result data0=0x1234, wb_reg=5 -> next cycle wb_valid=1, wb_data=0x1234, wb_reg_r=5, no stall.
- LB addr 0x103, extend=1, rdata=0x80FFFFFF, ack 3 cycles after req -> wstrb=0, stall 4 cycles, wb_data=0xFFFFFF80.
- SH addr 0x202, data1=0xABCD -> dmem_addr=0x200, wstrb=4'b1100, wdata=0xABCDABCD, wb_valid stays 0.
- LW addr 0x101 -> no dmem_req, mem_misaligned=1, fault_pc=mem_pc, no stall.
- BEQ data0=0, br_inv=1, data1=0x40 -> br_taken=1, br_target=0x40; JAL data0=0x14, data1=0x80 -> br_taken, wb_data=0x14.
- Reset asserted while BUSY, then ack -> dmem_req=0, wb_valid=0, state IDLE.
